// File: rtl/cpu_defs.sv
// Shared fetch-side definitions: bus widths, fetch FSM encoding, queue entry layout.
package cpu_defs;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

   function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch unit buses: memory-controller instruction port and decoder handshake.
interface inst_fetch_if;
   import cpu_defs::*;

   logic              mc_req;
   logic [ADDR_W-1:0] mc_addr;
   logic              mc_flag;
   logic [INST_W-1:0] mc_inst;

   logic              out_valid;
   logic [INST_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
   logic              out_ready;

   modport master (
      output mc_req, mc_addr, out_valid, out_inst, out_pc,
      input  mc_flag, mc_inst, out_ready
   );

   modport slave (
      input  mc_req, mc_addr, out_valid, out_inst, out_pc,
      output mc_flag, mc_inst, out_ready
   );

endinterface

// File: rtl/inst_queue.sv
// In-order circular buffer of fetched {pc, inst} entries; clear wins over push/pop.
module inst_queue
   import cpu_defs::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  iq_entry_t                data_i,
   output iq_entry_t                head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   iq_entry_t       mem_q [DEPTH];
   logic [PW-1:0]   head_q;
   logic [PW-1:0]   tail_q;
   logic [PW:0]     count_q;
   logic            doPush;
   logic            doPop;

   assign doPush = push_i && (count_q != (PW+1)'(DEPTH));
   assign doPop  = pop_i && (count_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, inst: NOP};
      end else if (en_i) begin
         if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (doPush) begin
               mem_q[tail_q] <= data_i;
               tail_q        <= tail_q + 1'b1;
            end
            if (doPop) head_q <= head_q + 1'b1;
            unique case ({doPush, doPop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch initiator: PC, one-outstanding memory request, instruction queue.
// Optional direct-mapped icache enabled by defining INST_FETCH_ICACHE_EN.
module inst_fetch
   import cpu_defs::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0,
   parameter int                IQ_DEPTH = 4
`ifdef INST_FETCH_ICACHE_EN
   , parameter int              ICACHE_LINES = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   inst_fetch_if.master      bus
);

   localparam int CW = $clog2(IQ_DEPTH) + 1;

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mcAddr_q;
   logic              mcReq_q;

   logic [CW-1:0]     iqCount;
   iq_entry_t         iqHead;
   iq_entry_t         pushData_d;
   logic              iqHasRoom;
   logic              respOk;
   logic              iqPush;
   logic              iqPop;
   logic              outValid;
   logic              cacheHit;
   logic [INST_W-1:0] cacheInst;

`ifdef INST_FETCH_ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic              cacheValid_q [ICACHE_LINES];
   logic [TAG_W-1:0]  cacheTag_q   [ICACHE_LINES];
   logic [INST_W-1:0] cacheData_q  [ICACHE_LINES];
   logic [IDX_W-1:0]  lookupIdx;
   logic [IDX_W-1:0]  fillIdx;

   assign lookupIdx = pc_q[IDX_W+1:2];
   assign fillIdx   = mcAddr_q[IDX_W+1:2];
   assign cacheHit  = cacheValid_q[lookupIdx] && (cacheTag_q[lookupIdx] == pc_q[ADDR_W-1:IDX_W+2]);
   assign cacheInst = cacheData_q[lookupIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ICACHE_LINES; i++) cacheValid_q[i] <= 1'b0;
      end else if (rdy && respOk) begin
         cacheValid_q[fillIdx] <= 1'b1;
      end
   end

   // Tag/data need no reset: the valid bit gates every use.
   always_ff @(posedge clk) begin
      if (!rst && rdy && respOk) begin
         cacheTag_q[fillIdx]  <= mcAddr_q[ADDR_W-1:IDX_W+2];
         cacheData_q[fillIdx] <= bus.mc_inst;
      end
   end
`else
   assign cacheHit  = 1'b0;
   assign cacheInst = NOP;
`endif

   assign iqHasRoom = iqCount < CW'(IQ_DEPTH);
   assign respOk    = (state_q == IF_WAIT) && bus.mc_flag && !flush;
   assign iqPush    = respOk || ((state_q == IF_IDLE) && cacheHit && iqHasRoom && !flush);
   assign outValid  = iqCount != '0;
   assign iqPop     = outValid && bus.out_ready;

   always_comb begin
      pushData_d = '{pc: mcAddr_q, inst: bus.mc_inst};
      if (state_q == IF_IDLE) pushData_d = '{pc: pc_q, inst: cacheInst};
   end

   inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .en_i    (rdy),
      .push_i  (iqPush),
      .pop_i   (iqPop),
      .clear_i (flush),
      .data_i  (pushData_d),
      .head_o  (iqHead),
      .count_o (iqCount)
   );

   // A request already on the bus cannot be withdrawn, so a flush during WAIT parks in DROP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IF_IDLE;
         pc_q     <= RESET_PC;
         mcReq_q  <= 1'b0;
         mcAddr_q <= '0;
      end else if (rdy) begin
         unique case (state_q)
            IF_IDLE: begin
               if (flush) begin
                  pc_q <= alignPc(flush_pc);
               end else if (iqHasRoom) begin
                  if (cacheHit) begin
                     pc_q <= pc_q + 32'd4;
                  end else begin
                     mcReq_q  <= 1'b1;
                     mcAddr_q <= pc_q;
                     state_q  <= IF_WAIT;
                  end
               end
            end
            IF_WAIT: begin
               if (flush) begin
                  pc_q <= alignPc(flush_pc);
                  if (bus.mc_flag) begin
                     mcReq_q <= 1'b0;
                     state_q <= IF_IDLE;
                  end else begin
                     state_q <= IF_DROP;
                  end
               end else if (bus.mc_flag) begin
                  pc_q    <= pc_q + 32'd4;
                  mcReq_q <= 1'b0;
                  state_q <= IF_IDLE;
               end
            end
            IF_DROP: begin
               if (flush) pc_q <= alignPc(flush_pc);
               if (bus.mc_flag) begin
                  mcReq_q <= 1'b0;
                  state_q <= IF_IDLE;
               end
            end
            default: state_q <= IF_IDLE;
         endcase
      end
   end

   assign bus.mc_req    = mcReq_q;
   assign bus.mc_addr   = mcAddr_q;
   assign bus.out_valid = outValid;
   assign bus.out_inst  = iqHead.inst;
   assign bus.out_pc    = iqHead.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a 2-cycle-latency memory responder, request/pop logs, hand-computed expectations.
module tb_inst_fetch;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        flush;
   logic [31:0] flush_pc;

   inst_fetch_if bus();

   inst_fetch #(.RESET_PC(32'h0), .IQ_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .flush    (flush),
      .flush_pc (flush_pc),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   int          memCnt   = 0;
   logic        prevReq  = 1'b0;
   logic [31:0] heldAddr = '0;
   logic [31:0] reqLog[$];
   logic [31:0] popPcLog[$];
   logic [31:0] popInstLog[$];

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdyV, input logic flushV, input logic [31:0] flushPcV, input logic readyV);
      rdy           = rdyV;
      flush         = flushV;
      flush_pc      = flushPcV;
      bus.out_ready = readyV;
   endtask

   // One clock: memory responder and pop capture at negedge, request capture just after posedge.
   task automatic cycle();
      @(negedge clk);
      if (rst) begin
         memCnt      = 0;
         bus.mc_flag = 1'b0;
      end else if (!rdy) begin
         bus.mc_flag = bus.mc_req;
         bus.mc_inst = 32'hDEAD_DEAD;
      end else if (bus.mc_req) begin
         memCnt++;
         bus.mc_flag = (memCnt == 2);
         bus.mc_inst = memWord(bus.mc_addr);
      end else begin
         memCnt      = 0;
         bus.mc_flag = 1'b0;
      end
      if (!rst && rdy && bus.mc_flag && !bus.mc_req) checkOutput("flag_in_idle", 32'd1, 32'd0);
      if (!rst && rdy && !flush && bus.out_valid && bus.out_ready) begin
         popPcLog.push_back(bus.out_pc);
         popInstLog.push_back(bus.out_inst);
      end
      @(posedge clk);
      #1;
      if (!rst && bus.mc_req && !prevReq) reqLog.push_back(bus.mc_addr);
      if (bus.mc_req && prevReq) checkOutput("addr_stable", bus.mc_addr, heldAddr);
      if (bus.mc_req) heldAddr = bus.mc_addr;
      prevReq = bus.mc_req;
   endtask

   task automatic applyReset(input logic readyV);
      applyStimulus(1'b1, 1'b0, 32'h0, readyV);
      rst = 1'b1;
      cycle();
      cycle();
      reqLog.delete();
      popPcLog.delete();
      popInstLog.delete();
      rst = 1'b0;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic runUntilPops(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && popPcLog.size() < n; i++) cycle();
      checkOutput(tag, 32'(popPcLog.size() >= n), 32'd1);
   endtask

   task automatic runUntilReq(input logic [31:0] addr, input int budget, input string tag);
      for (int i = 0; i < budget && !(bus.mc_req && bus.mc_addr == addr); i++) cycle();
      checkOutput(tag, 32'(bus.mc_req && bus.mc_addr == addr), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.mc_flag   = 1'b0;
      bus.mc_inst   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = '0;

      // Reset state, then three in-order fetches drained immediately
      applyReset(1'b1);
      checkOutput("rst_req", 32'(bus.mc_req), 32'd0);
      checkOutput("rst_addr", bus.mc_addr, 32'h0);
      checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
      cycle();
      checkOutput("first_req", 32'(bus.mc_req), 32'd1);
      checkOutput("first_addr", bus.mc_addr, 32'h0);
      runUntilPops(3, 60, "seq_pops_done");
      checkOutput("seq_req0", reqLog[0], 32'h0);
      checkOutput("seq_req1", reqLog[1], 32'h4);
      checkOutput("seq_req2", reqLog[2], 32'h8);
      checkOutput("seq_pc0", popPcLog[0], 32'h0);
      checkOutput("seq_pc1", popPcLog[1], 32'h4);
      checkOutput("seq_pc2", popPcLog[2], 32'h8);
      checkOutput("seq_inst0", popInstLog[0], 32'hC0DE_0000);
      checkOutput("seq_inst2", popInstLog[2], 32'hC0DE_0008);

      // Queue fills to 4 with no consumer, one pop frees exactly one fetch
      applyReset(1'b0);
      runCycles(30);
      checkOutput("full_reqs", 32'(reqLog.size()), 32'd4);
      checkOutput("full_last_addr", reqLog[3], 32'hC);
      checkOutput("full_req_idle", 32'(bus.mc_req), 32'd0);
      checkOutput("full_head_pc", bus.out_pc, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      cycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      runCycles(12);
      checkOutput("refill_reqs", 32'(reqLog.size()), 32'd5);
      checkOutput("refill_addr", reqLog[4], 32'h10);
      checkOutput("refill_req_idle", 32'(bus.mc_req), 32'd0);
      checkOutput("refill_one_pop", 32'(popPcLog.size()), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      runUntilPops(5, 80, "drain_done");
      checkOutput("drain_pc1", popPcLog[1], 32'h4);
      checkOutput("drain_pc4", popPcLog[4], 32'h10);
      checkOutput("drain_inst4", popInstLog[4], 32'hC0DE_0010);

      // Flush while waiting on 0x8: request held, word dropped, refetch from 0x100
      applyReset(1'b0);
      runUntilReq(32'h8, 40, "drop_reach_8");
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
      cycle();
      checkOutput("drop_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("drop_req_held", 32'(bus.mc_req), 32'd1);
      checkOutput("drop_addr_held", bus.mc_addr, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      cycle();
      checkOutput("drop_req_done", 32'(bus.mc_req), 32'd0);
      checkOutput("drop_not_queued", 32'(bus.out_valid), 32'd0);
      runUntilPops(1, 40, "drop_pop_done");
      checkOutput("drop_next_req", reqLog[3], 32'h100);
      checkOutput("drop_pop_pc", popPcLog[0], 32'h100);
      checkOutput("drop_pop_inst", popInstLog[0], 32'hC0DE_0100);

      // Flush coinciding with the response for 0x4; flush_pc low bits are cleared
      applyReset(1'b1);
      runUntilReq(32'h4, 40, "cofl_reach_4");
      cycle();
      applyStimulus(1'b1, 1'b1, 32'h201, 1'b1);
      cycle();
      checkOutput("cofl_no_drop", 32'(bus.mc_req), 32'd0);
      checkOutput("cofl_valid", 32'(bus.out_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      cycle();
      checkOutput("cofl_req", 32'(bus.mc_req), 32'd1);
      checkOutput("cofl_addr", bus.mc_addr, 32'h200);
      runUntilPops(2, 40, "cofl_pops_done");
      checkOutput("cofl_pop0", popPcLog[0], 32'h0);
      checkOutput("cofl_pop1", popPcLog[1], 32'h200);
      checkOutput("cofl_inst1", popInstLog[1], 32'hC0DE_0200);

      // rdy low for 5 cycles mid-WAIT: flush, pops and stray flags all ignored
      applyReset(1'b0);
      runUntilReq(32'h4, 40, "frz_reach_4");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
         cycle();
         checkOutput($sformatf("frz_req_%0d", i), 32'(bus.mc_req), 32'd1);
         checkOutput($sformatf("frz_addr_%0d", i), bus.mc_addr, 32'h4);
         checkOutput($sformatf("frz_valid_%0d", i), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("frz_head_%0d", i), bus.out_pc, 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      runCycles(2);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      runUntilPops(3, 60, "frz_pops_done");
      checkOutput("frz_pop0", popPcLog[0], 32'h0);
      checkOutput("frz_pop1", popPcLog[1], 32'h4);
      checkOutput("frz_pop2", popPcLog[2], 32'h8);
      checkOutput("frz_inst1", popInstLog[1], 32'hC0DE_0004);
      checkOutput("frz_req2", reqLog[2], 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator: owns the PC and issues word requests to the memory controller's instruction port (req/addr → flag/inst).
- Buffers returned instructions in a small in-order queue.
- Presents the queue head to the decoder with a valid/ready handshake.
- Accepts redirect/flush from the commit/branch side, including while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- IQ_DEPTH, 4, instruction queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- mc_req  out  1  fetch request to memory controller
- mc_addr  out  32  fetch address (word-aligned)
- mc_flag  in  1  one-cycle pulse: mc_inst valid for the outstanding request
- mc_inst  in  32  returned instruction word
- flush  in  1  redirect; discard queue and any in-flight fetch
- flush_pc  in  32  new PC when flush=1
- out_valid  out  1  queue head valid
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- out_ready  in  1  decoder accepts head this cycle

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is synchronous, active-high.
  - On reset: mc_req=0, mc_addr=0, out_valid=0, queue empty, pc=RESET_PC, state=IDLE.
- rdy=0 holds every register. All inputs are ignored that cycle, including flush and mc_flag; the memory controller is frozen too.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, result wanted.
  - DROP: request outstanding, result to be discarded.
- IDLE:
  - If !flush and count < IQ_DEPTH: register mc_req=1, mc_addr=pc; go WAIT.
  - Request is visible the cycle after the decision.
- WAIT:
  - mc_req and mc_addr are held stable until mc_flag.
  - On mc_flag with no flush: push {mc_inst, mc_addr}, pc += 4 (32-bit wrap), mc_req=0, go IDLE.
  - No back-to-back issue: minimum 1 IDLE cycle per fetch.
- Flush:
  - Takes priority over everything in the same cycle.
  - Queue is cleared (count=0); out_valid=0 next cycle.
  - pc=flush_pc (low 2 bits forced to 0).
  - A pop in the flush cycle is not counted.
  - From IDLE: stay IDLE; the next request uses flush_pc.
  - From WAIT without mc_flag: go DROP; mc_req stays asserted, because the request cannot be cancelled.
  - From WAIT with mc_flag the same cycle: the word is discarded; mc_req=0, go IDLE.
  - In DROP: pc updated again, stay DROP (or go IDLE if mc_flag the same cycle).
- DROP: on mc_flag, discard mc_inst, mc_req=0, go IDLE.
- Queue:
  - Circular buffer; head/tail pointers are log2(IQ_DEPTH) bits and wrap.
  - count is log2(IQ_DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop on out_valid && out_ready; outputs come straight from the head registers.
  - Full: no new request issues. An outstanding request always has a free slot, because issue requires count < IQ_DEPTH and pops only free slots.
  - Empty: out_valid=0; out_inst/out_pc are don't-care but stable.
- mc_flag in IDLE is illegal; ignore it. A bench assertion flags it.

Optional Feature:
- Macro: INST_FETCH_ICACHE_EN.
- When defined:
  - Adds a direct-mapped, word-granular icache, parameter ICACHE_LINES (default 64).
  - Index = pc[log2(ICACHE_LINES)+1:2]; the tag is the remaining upper bits; valid bits are cleared on rst.
  - In IDLE, a hit (with count < IQ_DEPTH, no flush) pushes the cached word in the same cycle without asserting mc_req, and pc += 4.
  - A miss issues normally; on mc_flag in WAIT the line is filled. DROP results are not filled.
  - flush does not invalidate the cache.
- When undefined: every fetch goes to memory; no cache storage is synthesized.

Decomposition:
- Shared package cpu_defs:
  - ADDR_W=32, INST_W=32.
  - Fetch state encoding IF_IDLE/IF_WAIT/IF_DROP.
  - NOP encoding 32'h00000013.
- One natural sub-module: inst_queue (parameterized FIFO carrying {pc, inst}, with push/pop/clear/count).

Test Plan:
- Reset, RESET_PC=0, memory returns mc_flag 2 cycles after req, out_ready=1 → requests at 0x0, 0x4, 0x8 in order; out_pc 0x0/0x4/0x8 with matching insts; mc_addr stable while req high.
- out_ready=0, IQ_DEPTH=4 → exactly 4 fetches (0x0–0xC), then mc_req stays 0. Raise out_ready for one cycle → one pop, then exactly one new fetch to 0x10.
- flush with flush_pc=0x100 while WAIT on 0x8 → mc_req held until flag; that word is dropped; next mc_addr=0x100; queue empty the cycle after flush.
- flush the same cycle as mc_flag for 0x4, flush_pc=0x200 → word not enqueued; next request 0x200, no DROP state entered.
- rdy=0 for 5 cycles mid-WAIT with flag pulses suppressed → no state or pointer change; resumes identically when rdy=1.
- With INST_FETCH_ICACHE_EN: loop 0x0→0xC then flush to 0x0 → the second pass issues no mc_req and delivers 4 insts on consecutive cycles.
